// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller holding the HI/LO register pair.
// A multiply-class or divide-class op computes its result at the start edge
// into pending registers. The unit then stays busy for MULT_CYCLES or
// DIV_CYCLES cycles and commits the pending values to hi/lo when the count
// runs out. MTHI/MTLO write hi/lo directly, with no busy cycles.
//
// Optional feature: define MDU_MADD_EN to enable MADD/MSUB (op 110/111).
// Without it, those ops are ignored.
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - synchronous active-low reset
//   start    - E-stage MD instruction valid
//   op       - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//              100 MTHI, 101 MTLO, 110 MADD, 111 MSUB
//   a, b     - rs / rt operands (forwarded)
//   d_is_md  - D-stage instruction touches HI/LO
//   busy     - operation in progress
//   md_stall - combinational stall request to the hazard unit
//   hi, lo   - architectural HI/LO registers
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_ok;   // cleared on divide-by-zero so hi/lo are kept

  logic [63:0] prod_s, prod_u, mul_res;
  logic [31:0] div_q, div_r;

  // Products are taken on 64-bit sign/zero-extended operands.
  // The low 64 bits are exact for both signed and unsigned multiplies.
  always_comb begin
    prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u  = {32'b0, a} * {32'b0, b};
    mul_res = prod_s;
    case (op)
      OP_MULTU: mul_res = prod_u;
`ifdef MDU_MADD_EN
      OP_MADD:  mul_res = {hi, lo} + prod_s;
      OP_MSUB:  mul_res = {hi, lo} - prod_s;
`endif
      default:  mul_res = prod_s;
    endcase
  end

  // Divide by zero yields don't-care results, which are never committed.
  // The INT_MIN / -1 case is special-cased to avoid signed overflow.
  always_comb begin
    div_q = '0;
    div_r = '0;
    if (b != 32'd0) begin
      if (op == OP_DIVU) begin
        div_q = a / b;
        div_r = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        div_q = a;
        div_r = '0;
      end else begin
        div_q = $signed(a) / $signed(b);
        div_r = $signed(a) % $signed(b);
      end
    end
  end

  assign md_stall = d_is_md & (busy | (start & (op != OP_MTHI) & (op != OP_MTLO)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU: begin
                {pend_hi, pend_lo} <= mul_res;
                pend_ok <= 1'b1;
                cnt     <= CW'(MULT_CYCLES);
                busy    <= 1'b1;
                state   <= MUL;
              end
`ifdef MDU_MADD_EN
              OP_MADD, OP_MSUB: begin
                {pend_hi, pend_lo} <= mul_res;
                pend_ok <= 1'b1;
                cnt     <= CW'(MULT_CYCLES);
                busy    <= 1'b1;
                state   <= MUL;
              end
`endif
              OP_DIV, OP_DIVU: begin
                pend_lo <= div_q;
                pend_hi <= div_r;
                pend_ok <= (b != 32'd0);
                cnt     <= CW'(DIV_CYCLES);
                busy    <= 1'b1;
                state   <= DIV;
              end
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              default: ;
            endcase
          end
        end
        MUL, DIV: begin
          // Starts are ignored here. The count runs down and the unit
          // commits on the edge that reaches zero.
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (pend_ok) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl (default parameters).
// The MADD/MSUB test follows MDU_MADD_EN: if the macro is defined the ops are
// checked for their results; otherwise they are checked for being ignored.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b0;
  logic [31:0] a = '0, b = '0;
  logic        d_is_md = 1'b0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MTHI = 3'd4, MTLO = 3'd5, MADD = 3'd6, MSUB = 3'd7;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .d_is_md(d_is_md), .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
  endtask

  // Counts the busy cycles that remain, bounded at 40.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    end
    // Reset wins over a simultaneous MTHI.
    start = 1'b1; op = MTHI; a = 32'h5;
    tick();
    start = 1'b0;
    checks++;
    if (hi !== 32'd0) begin
      errors++;
      $display("FAIL reset_priority: hi=%h want 0", hi);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n;
    issue(MULT, 32'hFFFF_FFFE, 32'd3);
    wait_idle(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL mult_busy_len: got %0d want 5", n);
    end
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_result: hi=%h lo=%h want ffffffff/fffffffa", hi, lo);
    end
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    checks++;
    if (hi !== 32'd1 || lo !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_result: hi=%h lo=%h want 00000001/fffffffe", hi, lo);
    end
  endtask

  task automatic test_div();
    int n;
    issue(DIVU, 32'd7, 32'd2);
    wait_idle(n);
    checks++;
    if (n !== 10) begin
      errors++;
      $display("FAIL divu_busy_len: got %0d want 10", n);
    end
    checks++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      errors++;
      $display("FAIL divu_result: hi=%h lo=%h want 1/3", hi, lo);
    end
    issue(DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_signed: hi=%h lo=%h want ffffffff/fffffffd", hi, lo);
    end
  endtask

  task automatic test_stall_and_ignore();
    int n;
    d_is_md = 1'b1;
    start = 1'b1; op = MULT; a = 32'd4; b = 32'd5;
    #1;
    checks++;
    if (md_stall !== 1'b1) begin
      errors++;
      $display("FAIL stall_start_cycle: got %b want 1", md_stall);
    end
    tick();
    // A second start while busy must be ignored.
    op = DIVU; a = 32'd100; b = 32'd3;
    n = 0;
    while (busy && n < 40) begin
      checks++;
      if (md_stall !== 1'b1) begin
        errors++;
        $display("FAIL stall_busy_cycle%0d: got %b want 1", n, md_stall);
      end
      n++;
      tick();
    end
    start = 1'b0;
    #1;
    checks++;
    if (n !== 5 || md_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_after: busy_len=%0d stall=%b want 5/0", n, md_stall);
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd20 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_while_busy: hi=%h lo=%h busy=%b want 0/14/0", hi, lo, busy);
    end
    // MTHI does not stall, even with a D-stage HI/LO instruction.
    start = 1'b1; op = MTHI;
    #1;
    checks++;
    if (md_stall !== 1'b0) begin
      errors++;
      $display("FAIL stall_mthi: got %b want 0", md_stall);
    end
    start = 1'b0;
    d_is_md = 1'b0;
  endtask

  task automatic test_div_zero();
    int n;
    issue(MTHI, 32'h1234, 32'd0);
    issue(MTLO, 32'h5678, 32'd0);
    checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h busy=%b want 1234/5678/0", hi, lo, busy);
    end
    issue(DIV, 32'd99, 32'd0);
    wait_idle(n);
    checks++;
    if (n !== 10 || hi !== 32'h1234 || lo !== 32'h5678) begin
      errors++;
      $display("FAIL div_by_zero: len=%0d hi=%h lo=%h want 10/1234/5678", n, hi, lo);
    end
  endtask

  task automatic test_reset_mid_op();
    issue(MULT, 32'd6, 32'd7);  // now in busy cycle 1
    tick(); tick();             // busy cycle 3
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    repeat (8) tick();
    checks++;
    if (lo !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL no_late_commit: lo=%h busy=%b want 0/0", lo, busy);
    end
  endtask

  task automatic test_madd();
    int n;
    issue(MTHI, 32'd0, 32'd0);
    issue(MTLO, 32'd10, 32'd0);
    issue(MADD, 32'd2, 32'd3);
`ifdef MDU_MADD_EN
    wait_idle(n);
    checks++;
    if (n !== 4 || hi !== 32'd0 || lo !== 32'd16) begin
      errors++;
      $display("FAIL madd: rest_len=%0d hi=%h lo=%h want 4/0/10", n, hi, lo);
    end
    issue(MSUB, 32'd4, 32'd5);
    wait_idle(n);
    checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL msub: hi=%h lo=%h want ffffffff/fffffffc", hi, lo);
    end
`else
    n = 0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd10) begin
      errors++;
      $display("FAIL madd_disabled: busy=%b hi=%h lo=%h want 0/0/a", busy, hi, lo);
    end
    issue(MSUB, 32'd4, 32'd5);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd10 || n !== 0) begin
      errors++;
      $display("FAIL msub_disabled: busy=%b hi=%h lo=%h want 0/0/a", busy, hi, lo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall_and_ignore();
    test_div_zero();
    test_reset_mid_op();
    test_madd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL provide parameter MULT_CYCLES, default 5, busy duration of multiply-class ops.
REQ-002 SHALL provide parameter DIV_CYCLES, default 10, busy duration of divide-class ops.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port start  input  1  E-stage MD instruction valid; sampled each edge.
REQ-006 SHALL have port op  input  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
REQ-007 SHALL have port a  input  32  rs operand (forwarded value).
REQ-008 SHALL have port b  input  32  rt operand (forwarded value).
REQ-009 SHALL have port d_is_md  input  1  D-stage instruction reads or writes HI/LO (mult/div/mfhi/mflo/mthi/mtlo/madd/msub).
REQ-010 SHALL have port busy  output  1  operation in progress.
REQ-011 SHALL have port md_stall  output  1  stall request to the hazard unit.
REQ-012 SHALL have port hi  output  32  HI register.
REQ-013 SHALL have port lo  output  32  LO register.

Function
REQ-014 SHALL implement states IDLE, MUL, DIV with a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 In IDLE with start=1 and op in {MULT, MULTU, MADD, MSUB}, SHALL compute the result from a, b at that edge into pending registers, load the counter with MULT_CYCLES, and enter MUL.
REQ-016 In IDLE with start=1 and op in {DIV, DIVU}, SHALL latch quotient to pending-LO and remainder to pending-HI, load the counter with DIV_CYCLES, and enter DIV.
REQ-017 MULT/DIV SHALL use two's-complement signed arithmetic; MULTU/DIVU SHALL use unsigned arithmetic; the product SHALL be 64 bits {HI,LO}; signed remainder SHALL take the dividend's sign.
REQ-018 busy SHALL be 1 in MUL/DIV and 0 in IDLE; busy SHALL stay high exactly N cycles after the start edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-019 On the edge where the counter reaches 0, SHALL commit the pending values to hi/lo and return to IDLE; the new hi/lo SHALL be visible in the first cycle with busy=0.
REQ-020 DIV/DIVU with b=0 SHALL run the full DIV_CYCLES with busy=1 and SHALL leave hi/lo unchanged.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write a to hi/lo at that edge, with no busy cycles.
REQ-022 start while busy=1 SHALL be ignored: no state, counter or hi/lo change.
REQ-023 md_stall SHALL be combinational: d_is_md & (busy | (start & op not in {MTHI, MTLO})).
REQ-024 hi/lo SHALL hold their values whenever no commit or MTHI/MTLO write occurs.

Reset
REQ-025 reset=0 at an edge SHALL force IDLE, counter 0, busy=0, hi=0, lo=0, and pending registers=0.
REQ-026 reset during MUL/DIV SHALL discard the operation; no commit SHALL occur afterwards.
REQ-027 reset SHALL take priority over start at the same edge.

Configuration
REQ-028 With macro MDU_MADD_EN defined, MADD SHALL commit {hi,lo}+signed(a*b) and MSUB SHALL commit {hi,lo}-signed(a*b), both using hi/lo as sampled at the start edge and taking MULT_CYCLES.
REQ-029 Without MDU_MADD_EN, op 110/111 with start=1 SHALL be ignored: busy stays 0 and hi/lo are unchanged.

Verification
REQ-030 MULT a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-031 DIVU a=7, b=2 -> busy high 10 cycles; then lo=3, hi=1; DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 Start MULT, assert d_is_md on cycles 0-6 -> md_stall=1 on the start cycle and the 5 busy cycles, 0 afterwards; second start during busy -> ignored.
REQ-033 DIV with b=0 after MTHI a=0x1234, MTLO a=0x5678 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
REQ-034 reset=0 in busy cycle 3 of MULT 6*7 -> busy=0, hi=lo=0 next cycle; no later commit of 42.
REQ-035 With MDU_MADD_EN: hi=0, lo=10, MADD a=2, b=3 -> after 5 cycles lo=16; MSUB a=4, b=5 -> lo=0xFFFFFFFC, hi=0xFFFFFFFF.
